// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read address + read data channel bundle shared by the masters and the memory port.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic              rlast;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rlast, rdata, rid, rresp
  );

  // Size and burst type are fixed by the arbiter, so the receiving side never looks at them.
  modport slave (
    input  arvalid, araddr, arid, arlen, rready,
    output arready, rvalid, rlast, rdata, rid, rresp
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI4 read arbiter: round-robin whole-burst grants,
// R channel routed back to the owner, sticky beat-count vs ARLEN error flag.
module axi_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic clk,
  input  logic rst,
  axi_rd_arbiter_if.slave  m0,
  axi_rd_arbiter_if.slave  m1,
  axi_rd_arbiter_if.master s,
  output logic grant,
  output logic busy,
  output logic err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state_reg, state_next;
  logic              last_reg, own_reg, err_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [7:0]        len_reg;
  logic [8:0]        beat_reg;
  logic              win, take, beat;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    win        = 1'b0;
    take       = 1'b0;
    beat       = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rlast   = 1'b0;
    m0.rdata   = '0;
    m0.rid     = '0;
    m0.rresp   = '0;
    m1.rvalid  = 1'b0;
    m1.rlast   = 1'b0;
    m1.rdata   = '0;
    m1.rid     = '0;
    m1.rresp   = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    case (state_reg)
      IDLE: begin
        // On a tie the master that did not own the previous burst wins.
        win  = (m0.arvalid && m1.arvalid) ? ~last_reg : m1.arvalid;
        take = m0.arvalid | m1.arvalid;
        if (take) begin
          m0.arready = ~win;
          m1.arready = win;
          state_next = ADDR;
        end
      end
      ADDR: begin
        s.arvalid = 1'b1;
        if (s.arready) state_next = DATA;
      end
      DATA: begin
        if (own_reg) begin
          m1.rvalid = s.rvalid;
          m1.rlast  = s.rlast;
          m1.rdata  = s.rdata;
          m1.rid    = s.rid;
          m1.rresp  = s.rresp;
          s.rready  = m1.rready;
        end else begin
          m0.rvalid = s.rvalid;
          m0.rlast  = s.rlast;
          m0.rdata  = s.rdata;
          m0.rid    = s.rid;
          m0.rresp  = s.rresp;
          s.rready  = m0.rready;
        end
        beat = s.rvalid & s.rready;
        if (beat && s.rlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= 1'b1;
      own_reg  <= 1'b0;
      addr_reg <= '0;
      id_reg   <= '0;
      len_reg  <= '0;
      beat_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (take) begin
        own_reg  <= win;
        addr_reg <= win ? m1.araddr : m0.araddr;
        id_reg   <= win ? m1.arid   : m0.arid;
        len_reg  <= win ? m1.arlen  : m0.arlen;
        beat_reg <= '0;
      end
      // beat_reg counts beats already accepted, so the rlast beat must see len.
      if (beat) begin
        beat_reg <= beat_reg + 9'd1;
        if (s.rlast) begin
          if (beat_reg != {1'b0, len_reg}) err_reg <= 1'b1;
          last_reg <= own_reg;
        end else if (beat_reg == {1'b0, len_reg}) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  assign s.araddr  = addr_reg;
  assign s.arid    = id_reg;
  assign s.arlen   = len_reg;
  assign s.arsize  = 3'b011;
  assign s.arburst = 2'b01;
  assign grant     = own_reg;
  assign busy      = (state_reg != IDLE);
  assign err       = err_reg;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: transaction-level model checked every cycle,
// plus literal expectations on grant order, delivered beats and the error flag.
module tb_axi_rd_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [7:0]    len;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grant, busy, err;
  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) m_bus [2] ();
  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) s_bus ();

  axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .m0(m_bus[0]), .m1(m_bus[1]), .s(s_bus),
    .grant(grant), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  logic          mv_arvalid [2];
  logic [AW-1:0] mv_araddr  [2];
  logic [IW-1:0] mv_arid    [2];
  logic [7:0]    mv_arlen   [2];
  logic          mv_rready  [2];
  logic          tog_mode   [2];
  logic          ob_arready [2];
  logic          ob_rvalid  [2];
  logic          ob_rlast   [2];
  logic [DW-1:0] ob_rdata   [2];
  logic [IW-1:0] ob_rid     [2];
  logic [1:0]    ob_rresp   [2];

  req_t          req_q   [2][$];
  logic [DW-1:0] rx_data [2][$];
  logic          rx_last [2][$];
  int            dut_grants[$];

  logic          sl_arready = 1'b0, sl_rvalid = 1'b0, sl_rlast = 1'b0;
  logic [DW-1:0] sl_rdata = '0;
  logic [IW-1:0] sl_rid = '0;
  logic [1:0]    sl_rresp = '0;
  int            sl_active = 0;
  int            ar_delay = 0;
  int            force_last = -1;

  assign s_bus.arready = sl_arready;
  assign s_bus.rvalid  = sl_rvalid;
  assign s_bus.rlast   = sl_rlast;
  assign s_bus.rdata   = sl_rdata;
  assign s_bus.rid     = sl_rid;
  assign s_bus.rresp   = sl_rresp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Masters: present queued requests back to back, log every delivered beat.
  for (genvar gi = 0; gi < 2; gi++) begin : g_m
    assign m_bus[gi].arvalid = mv_arvalid[gi];
    assign m_bus[gi].araddr  = mv_araddr[gi];
    assign m_bus[gi].arid    = mv_arid[gi];
    assign m_bus[gi].arlen   = mv_arlen[gi];
    assign m_bus[gi].arsize  = 3'b011;
    assign m_bus[gi].arburst = 2'b01;
    assign m_bus[gi].rready  = mv_rready[gi];
    assign ob_arready[gi]    = m_bus[gi].arready;
    assign ob_rvalid[gi]     = m_bus[gi].rvalid;
    assign ob_rlast[gi]      = m_bus[gi].rlast;
    assign ob_rdata[gi]      = m_bus[gi].rdata;
    assign ob_rid[gi]        = m_bus[gi].rid;
    assign ob_rresp[gi]      = m_bus[gi].rresp;

    initial begin : drv
      logic hs, rb, rl;
      logic [DW-1:0] rd;
      mv_arvalid[gi] = 1'b0;
      mv_araddr[gi]  = '0;
      mv_arid[gi]    = '0;
      mv_arlen[gi]   = '0;
      mv_rready[gi]  = 1'b1;
      tog_mode[gi]   = 1'b0;
      forever begin
        @(negedge clk);
        hs = mv_arvalid[gi] && ob_arready[gi];
        rb = ob_rvalid[gi] && mv_rready[gi];
        rd = ob_rdata[gi];
        rl = ob_rlast[gi];
        @(posedge clk); #1;
        if (hs) begin
          req_q[gi].delete(0);
          dut_grants.push_back(gi);
        end
        if (rb) begin
          rx_data[gi].push_back(rd);
          rx_last[gi].push_back(rl);
        end
        mv_arvalid[gi] = (req_q[gi].size() > 0);
        if (req_q[gi].size() > 0) begin
          mv_araddr[gi] = req_q[gi][0].addr;
          mv_arid[gi]   = req_q[gi][0].id;
          mv_arlen[gi]  = req_q[gi][0].len;
        end
        mv_rready[gi] = tog_mode[gi] ? ~mv_rready[gi] : 1'b1;
      end
    end
  end

  // Memory slave: optional AR stall, beat data = burst address + beat index.
  initial begin : slave
    logic ar_hs, r_hs, rst_now;
    logic [AW-1:0] cap_addr, sl_addr;
    logic [IW-1:0] cap_id, sl_id;
    logic [7:0]    cap_len, sl_len;
    int sl_beat, ar_wait, last_idx;
    sl_addr = '0; sl_id = '0; sl_len = '0; sl_beat = 0; ar_wait = 0;
    forever begin
      @(negedge clk);
      ar_hs    = s_bus.arvalid && sl_arready;
      r_hs     = sl_rvalid && s_bus.rready;
      rst_now  = rst;
      cap_addr = s_bus.araddr;
      cap_id   = s_bus.arid;
      cap_len  = s_bus.arlen;
      @(posedge clk); #1;
      if (rst_now) begin
        sl_active = 0; sl_arready = 1'b0; sl_rvalid = 1'b0; sl_rlast = 1'b0;
        sl_rdata = '0; sl_rid = '0; sl_rresp = '0; ar_wait = 0;
      end else begin
        if (r_hs && sl_rlast) sl_active = 0;
        else if (r_hs) sl_beat++;
        if (ar_hs) begin
          sl_active = 1; sl_beat = 0;
          sl_addr = cap_addr; sl_id = cap_id; sl_len = cap_len;
        end
        last_idx  = (force_last >= 0) ? force_last : int'(sl_len);
        sl_rvalid = (sl_active != 0);
        sl_rlast  = (sl_active != 0) && (sl_beat == last_idx);
        sl_rdata  = (sl_active != 0) ? sl_addr + 64'(sl_beat) : '0;
        sl_rid    = (sl_active != 0) ? sl_id : '0;
        sl_rresp  = (sl_active != 0) ? 2'(sl_beat) : 2'b00;
        if (s_bus.arvalid && sl_active == 0 && !ar_hs) begin
          sl_arready = (ar_wait >= ar_delay);
          ar_wait++;
        end else begin
          sl_arready = 1'b0;
          ar_wait = 0;
        end
      end
    end
  end

  // Reference model: one outstanding burst described by owner, request,
  // whether the slave took the address, and how many beats have been delivered.
  int md_busy = 0, md_sent = 0, md_own = 0, md_last = 1, md_err = 0, md_beats = 0, md_len = 0;
  logic [AW-1:0] md_addr = '0;
  logic [IW-1:0] md_id = '0;

  initial begin : model
    int win, any, own_data, dphase;
    forever begin
      @(negedge clk);
      any = (mv_arvalid[0] || mv_arvalid[1]) ? 1 : 0;
      if (mv_arvalid[0] && mv_arvalid[1]) win = 1 - md_last;
      else win = mv_arvalid[1] ? 1 : 0;
      dphase = (md_busy != 0 && md_sent != 0) ? 1 : 0;
      for (int m = 0; m < 2; m++) begin
        own_data = (dphase != 0 && md_own == m) ? 1 : 0;
        check($sformatf("m%0d_arready", m), ob_arready[m], (md_busy == 0 && any != 0 && win == m));
        check($sformatf("m%0d_rvalid", m), ob_rvalid[m], own_data != 0 ? s_bus.rvalid : 1'b0);
        check($sformatf("m%0d_rlast", m), ob_rlast[m], own_data != 0 ? s_bus.rlast : 1'b0);
        check($sformatf("m%0d_rdata", m), ob_rdata[m], own_data != 0 ? s_bus.rdata : 64'd0);
        check($sformatf("m%0d_rid", m), ob_rid[m], own_data != 0 ? s_bus.rid : 4'd0);
        check($sformatf("m%0d_rresp", m), ob_rresp[m], own_data != 0 ? s_bus.rresp : 2'd0);
      end
      check("s_arvalid", s_bus.arvalid, (md_busy != 0 && md_sent == 0));
      if (md_busy != 0 && md_sent == 0) begin
        check("s_araddr", s_bus.araddr, md_addr);
        check("s_arid", s_bus.arid, md_id);
        check("s_arlen", s_bus.arlen, 64'(md_len));
      end
      check("s_arsize", s_bus.arsize, 3'b011);
      check("s_arburst", s_bus.arburst, 2'b01);
      check("s_rready", s_bus.rready, dphase != 0 ? mv_rready[md_own] : 1'b0);
      check("grant", grant, 64'(md_own));
      check("busy", busy, (md_busy != 0));
      check("err", err, 64'(md_err));

      if (rst) begin
        md_busy = 0; md_sent = 0; md_own = 0; md_last = 1; md_err = 0; md_beats = 0;
      end else if (md_busy == 0) begin
        if (any != 0) begin
          md_busy = 1; md_sent = 0; md_own = win; md_beats = 0;
          md_addr = mv_araddr[win]; md_id = mv_arid[win]; md_len = int'(mv_arlen[win]);
        end
      end else if (md_sent == 0) begin
        if (sl_arready) md_sent = 1;
      end else if (s_bus.rvalid && mv_rready[md_own]) begin
        md_beats++;
        if (s_bus.rlast) begin
          if (md_beats != md_len + 1) md_err = 1;
          md_last = md_own;
          md_busy = 0;
        end else if (md_beats == md_len + 1) begin
          md_err = 1;
        end
      end
    end
  end

  task automatic push(input int m, input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [7:0] len);
    req_t r;
    r.addr = a; r.id = id; r.len = len;
    req_q[m].push_back(r);
  endtask

  task automatic clear_logs();
    for (int m = 0; m < 2; m++) begin
      rx_data[m].delete();
      rx_last[m].delete();
    end
    dut_grants.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((req_q[0].size() > 0 || req_q[1].size() > 0 || md_busy != 0 || sl_active != 0) && n < budget);
    check({name, "_done_in_budget"}, (n < budget), 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : main
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_m0_arready", ob_arready[0], 1'b0);
    check("rst_m1_rvalid", ob_rvalid[1], 1'b0);
    check("rst_m0_rdata", ob_rdata[0], 64'd0);
    check("rst_s_arvalid", s_bus.arvalid, 1'b0);
    check("rst_s_araddr", s_bus.araddr, 64'd0);
    check("rst_s_rready", s_bus.rready, 1'b0);
    check("rst_grant", grant, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);

    // Single read, len 0
    clear_logs();
    push(0, 64'h8000_0000, 4'h1, 8'd0);
    wait_done("single", 100);
    check("single_m0_beats", rx_data[0].size(), 1);
    check("single_m0_data", rx_data[0][0], 64'h8000_0000);
    check("single_m0_rlast", rx_last[0][0], 1'b1);
    check("single_m1_beats", rx_data[1].size(), 0);
    check("single_err", err, 1'b0);

    // Tie right after reset: M0 first
    do_reset();
    clear_logs();
    push(0, 64'h100, 4'h2, 8'd3);
    push(1, 64'h200, 4'h3, 8'd3);
    wait_done("tie", 200);
    check("tie_grant_count", dut_grants.size(), 2);
    check("tie_first", dut_grants[0], 0);
    check("tie_second", dut_grants[1], 1);
    check("tie_m0_beats", rx_data[0].size(), 4);
    check("tie_m0_last_data", rx_data[0][3], 64'h103);
    check("tie_m1_first_data", rx_data[1][0], 64'h200);
    check("tie_m1_last_data", rx_data[1][3], 64'h203);

    // Fairness: 3 bursts each, both always requesting
    do_reset();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      push(0, 64'h1000 + 64'(i * 16), 4'h4, 8'd1);
      push(1, 64'h2000 + 64'(i * 16), 4'h5, 8'd1);
    end
    wait_done("fair", 400);
    check("fair_grant_count", dut_grants.size(), 6);
    for (int i = 0; i < 6 && i < dut_grants.size(); i++)
      check($sformatf("fair_grant_%0d", i), dut_grants[i], 64'(i % 2));

    // Backpressure: AR stalled 5 cycles, owner toggles rready
    clear_logs();
    ar_delay = 5;
    tog_mode[0] = 1'b1;
    push(0, 64'h3000, 4'h7, 8'd7);
    wait_done("bp", 300);
    ar_delay = 0;
    tog_mode[0] = 1'b0;
    check("bp_beats", rx_data[0].size(), 8);
    for (int i = 0; i < 8 && i < rx_data[0].size(); i++)
      check($sformatf("bp_beat_%0d", i), rx_data[0][i], 64'h3000 + 64'(i));

    // Length error: rlast on the third beat of a len 3 burst, flag is sticky
    clear_logs();
    force_last = 2;
    push(1, 64'h300, 4'h5, 8'd3);
    wait_done("lenerr", 200);
    force_last = -1;
    check("lenerr_err", err, 1'b1);
    check("lenerr_m1_beats", rx_data[1].size(), 3);
    check("lenerr_m1_rlast", rx_last[1][2], 1'b1);
    clear_logs();
    push(0, 64'h400, 4'h6, 8'd1);
    wait_done("sticky", 200);
    check("sticky_err", err, 1'b1);
    check("sticky_m0_beats", rx_data[0].size(), 2);
    do_reset();
    @(negedge clk); #1;
    check("cleared_err", err, 1'b0);

    // Reset in the middle of a len 7 burst
    clear_logs();
    push(0, 64'h5000, 4'h8, 8'd7);
    n = 0;
    while (rx_data[0].size() < 3 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("midrst_reached_beat", (n < 200), 1'b1);
    do_reset();
    @(negedge clk); #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_m0_rvalid", ob_rvalid[0], 1'b0);
    check("midrst_m0_rdata", ob_rdata[0], 64'd0);
    check("midrst_s_rready", s_bus.rready, 1'b0);
    check("midrst_s_arvalid", s_bus.arvalid, 1'b0);
    check("midrst_grant", grant, 1'b0);
    clear_logs();
    push(1, 64'h600, 4'h9, 8'd2);
    wait_done("after_rst", 200);
    check("after_rst_m1_beats", rx_data[1].size(), 3);
    check("after_rst_m1_data", rx_data[1][2], 64'h602);
    check("after_rst_m0_beats", rx_data[0].size(), 0);
    check("after_rst_err", err, 1'b0);

    // Overrun: len 1 burst whose rlast comes on the fourth beat
    clear_logs();
    force_last = 3;
    push(0, 64'h700, 4'h1, 8'd1);
    wait_done("overrun", 200);
    force_last = -1;
    check("overrun_err", err, 1'b1);
    check("overrun_m0_beats", rx_data[0].size(), 4);
    check("overrun_m0_data", rx_data[0][3], 64'h703);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-master, one-slave AXI4 read-channel arbiter. It shares the single AXI read port of the block-RAM memory between the core's instruction-fetch master (M0) and load/store master (M1). It grants whole bursts round-robin and routes the R channel back to the owner. It also checks each burst's beat count against its ARLEN. Write channels bypass this block.

## Interface
- `ADDR_W`, 64: address width
- `DATA_W`, 64: data width
- `ID_W`, 4: AXI ID width
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `m{0,1}_arvalid_i`  input  1  master AR valid
- `m{0,1}_arready_o`  output  1  master AR ready
- `m{0,1}_araddr_i` / `m{0,1}_arid_i` / `m{0,1}_arlen_i`  input  ADDR_W / ID_W / 8  AR payload
- `m{0,1}_rvalid_o` / `m{0,1}_rlast_o`  output  1 / 1  routed R valid and last
- `m{0,1}_rdata_o` / `m{0,1}_rid_o` / `m{0,1}_rresp_o`  output  DATA_W / ID_W / 2  routed R payload
- `m{0,1}_rready_i`  input  1  master R ready
- `s_arvalid_o`  output  1  slave AR valid
- `s_arready_i`  input  1  slave AR ready
- `s_araddr_o` / `s_arid_o` / `s_arlen_o`  output  ADDR_W / ID_W / 8  latched AR payload
- `s_arsize_o` / `s_arburst_o`  output  3 / 2  constant 3'b011 (8 bytes) / 2'b01 (INCR)
- `s_rvalid_i` / `s_rlast_i` / `s_rdata_i` / `s_rid_i` / `s_rresp_i`  input  slave R channel
- `s_rready_o`  output  1  slave R ready
- `grant_o`  output  1  current or last owner (0 = M0, 1 = M1)
- `busy_o`  output  1  state != IDLE
- `err_o`  output  1  sticky burst-length mismatch flag

## Operation
- The FSM has three states: IDLE, ADDR, DATA.
- **IDLE**
  - Winner selection is combinational.
    - Only one `mX_arvalid_i` high: that master wins.
    - Both high: the master not equal to `last_q` wins.
  - `mX_arready_o` = 1 for the winner only, in the same cycle, so the handshake completes in IDLE.
  - On the handshake, latch addr/id/len into registers, set `own_q` = winner, clear `beat_q`, and go to ADDR.
- **ADDR**
  - `s_arvalid_o` = 1 with the latched payload.
  - Payload is stable until `s_arready_i`.
  - On `s_arready_i`, go to DATA.
  - Both `mX_arready_o` = 0.
- **DATA**
  - Owner outputs: `m[own]_r*_o` = `s_r*_i`, and `s_rready_o` = `m[own]_rready_i`.
  - Non-owner outputs: `rvalid_o` = 0, `rlast_o` = 0, payload = 0.
  - Each beat (`s_rvalid_i` & `s_rready_o`) increments `beat_q` (9 bits).
  - On the beat with `s_rlast_i`:
    - If `beat_q` != latched len, set `err_o`.
    - Set `last_q` = `own_q` and go to IDLE.
  - If `beat_q` reaches len+1 without rlast, set `err_o` and keep forwarding until rlast.
- `err_o` is sticky and is cleared only by `rst`.
- IDs pass through unmodified. Response ordering is guaranteed because only one burst is outstanding.
- `grant_o` = `own_q`; `busy_o` = (state != IDLE).

## Timing
- **Reset values:**
  - state IDLE.
  - All `arready_o`, `rvalid_o`, `rlast_o`, `s_arvalid_o`, and `s_rready_o` = 0.
  - All payload outputs = 0.
  - `last_q` = 1, so M0 wins the first tie.
  - `own_q` = 0, `grant_o` = 0, `busy_o` = 0, `err_o` = 0.
- **Reset mid-burst:** the FSM returns to IDLE on the next edge and outstanding beats are discarded. The bench must also reset the slave.
- **Added latency:** one cycle (master AR handshake at cycle N, `s_arvalid_o` at N+1). The R path is combinational with zero added latency.
- **Turnaround:** rlast beat at cycle N, IDLE at N+1, next master's AR handshake at N+1, `s_arvalid_o` at N+2.
- **No new grant before completion:** a new grant never occurs before the rlast handshake completes.
- **AXI rules enforced:**
  - Latched AR payload is stable while `s_arvalid_o` && !`s_arready_i`.
  - `s_arvalid_o` never drops before the handshake.
- **Fairness:** with both masters requesting continuously, grants alternate M0, M1, M0, and so on.

## Test plan
- **Single read:** M0 reads addr 0x80000000, len 0 → `s_arvalid_o` rises one cycle after the M0 handshake; 1 beat reaches M0 with rlast; M1 sees no rvalid; `err_o` = 0.
- **Tie after reset:** both masters request in the same cycle (M0 addr 0x100, M1 addr 0x200, len 3) → M0 granted first (4 beats), then M1 (4 beats); `grant_o` goes 0 then 1.
- **Fairness:** M0 and M1 request continuously for 6 bursts → grants strictly alternate, starting with M0.
- **Backpressure:** slave holds `s_arready_i` low 5 cycles, then owner toggles `rready` every other cycle on a len 7 burst → AR payload stable; all 8 beats delivered in order; `s_rready_o` mirrors the owner's rready.
- **Length error:** slave asserts rlast on beat 2 of a len 3 burst → burst completes; `err_o` = 1 and stays 1 through later correct bursts until `rst`.
- **Reset mid-burst:** `rst` asserted during beat 4 of a len 7 burst → next cycle IDLE with all outputs at reset values; subsequent M1 read completes normally.
